// File: rtl/input_debouncer.sv
// ============================================================================
// input_debouncer : two-flop synchronizer + four-state debounce FSM
// Rev 1.0
// ============================================================================
`default_nettype none

module input_debouncer #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic a,
  output logic changed,
  output logic busy
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_q, s2_q;
  logic          changed_q, changed_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= STABLE_LO;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

  // The first sample of a candidate value is counted on entry to WAIT, so the
  // accept test at N-1 corresponds to the N-th consecutive sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    changed_d = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s2_q) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s2_q) begin
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE_HI;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s2_q) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s2_q) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = STABLE_LO;
          changed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LO;
      end
    endcase
  end

  assign a       = (state_q == STABLE_HI) || (state_q == WAIT_LO);
  assign busy    = (state_q == WAIT_HI)   || (state_q == WAIT_LO);
  assign changed = changed_q;

endmodule

`default_nettype wire
